// File: rtl/idma_obi_mem_responder.sv
// OBI subordinate terminating an iDMA channel port onto one single-port SRAM bank.
// Optional address range check with error responses: define IDMA_OBI_RESP_ADDR_CHECK_EN.
module idma_obi_mem_responder #(
  parameter int unsigned          AddrWidth    = 32,
  parameter int unsigned          DataWidth    = 32,
  parameter int unsigned          IdWidth      = 1,
  parameter int unsigned          MemAddrWidth = 10,
  parameter logic [AddrWidth-1:0] BaseAddr     = AddrWidth'(32'h0001_0000),
  parameter int unsigned          RspFifoDepth = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    obi_req_i,
  output logic                    obi_gnt_o,
  input  logic [AddrWidth-1:0]    obi_addr_i,
  input  logic                    obi_we_i,
  input  logic [DataWidth/8-1:0]  obi_be_i,
  input  logic [DataWidth-1:0]    obi_wdata_i,
  input  logic [IdWidth-1:0]      obi_aid_i,
  output logic                    obi_rvalid_o,
  input  logic                    obi_rready_i,
  output logic [DataWidth-1:0]    obi_rdata_o,
  output logic [IdWidth-1:0]      obi_rid_o,
  output logic                    obi_err_o,
  output logic                    mem_req_o,
  input  logic                    mem_gnt_i,
  output logic                    mem_we_o,
  output logic [MemAddrWidth-1:0] mem_addr_o,
  output logic [DataWidth/8-1:0]  mem_be_o,
  output logic [DataWidth-1:0]    mem_wdata_o,
  input  logic [DataWidth-1:0]    mem_rdata_i
);

  localparam int unsigned StrbWidth  = DataWidth / 8;
  localparam int unsigned OffWidth   = $clog2(StrbWidth);
  localparam int unsigned PtrWidth   = (RspFifoDepth > 1) ? $clog2(RspFifoDepth) : 1;
  localparam int unsigned CntWidth   = $clog2(RspFifoDepth + 1);
  localparam int unsigned EntryWidth = DataWidth + IdWidth + 1;

  logic                    init_q;
  logic                    in_range;
  logic [MemAddrWidth-1:0] word_idx;
  logic                    credit;
  logic                    pop;
  logic                    push;
  logic                    fifo_empty;
  logic                    fifo_wr;
  logic                    fifo_rd;
  logic [CntWidth-1:0]     outstanding_q;
  logic [CntWidth-1:0]     fifo_cnt_q;
  logic [PtrWidth-1:0]     wr_ptr_q;
  logic [PtrWidth-1:0]     rd_ptr_q;
  logic                    meta_valid_q;
  logic                    meta_we_q;
  logic                    meta_err_q;
  logic [IdWidth-1:0]      meta_aid_q;
  logic [EntryWidth-1:0]   push_entry;
  logic [EntryWidth-1:0]   head_entry;
  logic [EntryWidth-1:0]   fifo_q [RspFifoDepth];

`ifdef IDMA_OBI_RESP_ADDR_CHECK_EN
  localparam logic [AddrWidth:0] BankBytes = (AddrWidth+1)'(1) << (OffWidth + MemAddrWidth);
  logic [AddrWidth-1:0] addr_off;

  // Base is bank-aligned, so the low offset bits are the word index directly.
  assign addr_off = obi_addr_i - BaseAddr;
  assign in_range = (obi_addr_i >= BaseAddr) && ({1'b0, addr_off} < BankBytes);
  assign word_idx = addr_off[OffWidth +: MemAddrWidth];
`else
  logic unused_addr;

  assign in_range    = 1'b1;
  assign word_idx    = obi_addr_i[OffWidth +: MemAddrWidth];
  assign unused_addr = ^{obi_addr_i, BaseAddr};
`endif

  // A retiring response frees its credit in the same cycle.
  assign pop       = obi_rvalid_o && obi_rready_i;
  assign credit    = init_q && ((outstanding_q < CntWidth'(RspFifoDepth)) || pop);
  assign obi_gnt_o = obi_req_i && credit && (!in_range || mem_gnt_i);

  assign mem_req_o   = obi_req_i && credit && in_range;
  assign mem_we_o    = obi_we_i;
  assign mem_addr_o  = word_idx;
  assign mem_be_o    = obi_be_i;
  assign mem_wdata_o = obi_wdata_i;

  // Response entry assembled one cycle after grant, when SRAM read data is valid.
  assign push       = meta_valid_q;
  assign push_entry = {(meta_we_q || meta_err_q) ? DataWidth'(0) : mem_rdata_i,
                       meta_aid_q, meta_err_q};
  assign fifo_empty = (fifo_cnt_q == CntWidth'(0));
  assign fifo_wr    = push && !(fifo_empty && pop);
  assign fifo_rd    = pop && !fifo_empty;
  assign head_entry = fifo_empty ? push_entry : fifo_q[rd_ptr_q];

  assign obi_rvalid_o = !fifo_empty || meta_valid_q;
  assign {obi_rdata_o, obi_rid_o, obi_err_o} = head_entry;

  // Grants are held off until the first clock after reset release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      init_q        <= 1'b0;
      outstanding_q <= '0;
      meta_valid_q  <= 1'b0;
      meta_we_q     <= 1'b0;
      meta_err_q    <= 1'b0;
      meta_aid_q    <= '0;
    end else begin
      init_q       <= 1'b1;
      meta_valid_q <= obi_gnt_o;
      if (obi_gnt_o) begin
        meta_we_q  <= obi_we_i;
        meta_err_q <= !in_range;
        meta_aid_q <= obi_aid_i;
      end
      if (obi_gnt_o && !pop) begin
        outstanding_q <= outstanding_q + CntWidth'(1);
      end else if (!obi_gnt_o && pop) begin
        outstanding_q <= outstanding_q - CntWidth'(1);
      end
    end
  end

  // Response FIFO control.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      if (fifo_wr) begin
        wr_ptr_q <= (wr_ptr_q == PtrWidth'(RspFifoDepth - 1)) ? '0 : wr_ptr_q + PtrWidth'(1);
      end
      if (fifo_rd) begin
        rd_ptr_q <= (rd_ptr_q == PtrWidth'(RspFifoDepth - 1)) ? '0 : rd_ptr_q + PtrWidth'(1);
      end
      if (fifo_wr && !fifo_rd) begin
        fifo_cnt_q <= fifo_cnt_q + CntWidth'(1);
      end else if (!fifo_wr && fifo_rd) begin
        fifo_cnt_q <= fifo_cnt_q - CntWidth'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (fifo_wr) begin
      fifo_q[wr_ptr_q] <= push_entry;
    end
  end

endmodule

// File: tb/tb_idma_obi_mem_responder.sv
// Directed self-checking bench for idma_obi_mem_responder with a small SRAM model.
// Follows IDMA_OBI_RESP_ADDR_CHECK_EN for the out-of-range step.
module tb_idma_obi_mem_responder;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        obi_req_i;
  logic        obi_gnt_o;
  logic [31:0] obi_addr_i;
  logic        obi_we_i;
  logic [3:0]  obi_be_i;
  logic [31:0] obi_wdata_i;
  logic [0:0]  obi_aid_i;
  logic        obi_rvalid_o;
  logic        obi_rready_i;
  logic [31:0] obi_rdata_o;
  logic [0:0]  obi_rid_o;
  logic        obi_err_o;
  logic        mem_req_o;
  logic        mem_gnt_i;
  logic        mem_we_o;
  logic [9:0]  mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  logic [31:0] mem [1024];
  int checks = 0;
  int errors = 0;

  idma_obi_mem_responder dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .obi_req_i    (obi_req_i),
    .obi_gnt_o    (obi_gnt_o),
    .obi_addr_i   (obi_addr_i),
    .obi_we_i     (obi_we_i),
    .obi_be_i     (obi_be_i),
    .obi_wdata_i  (obi_wdata_i),
    .obi_aid_i    (obi_aid_i),
    .obi_rvalid_o (obi_rvalid_o),
    .obi_rready_i (obi_rready_i),
    .obi_rdata_o  (obi_rdata_o),
    .obi_rid_o    (obi_rid_o),
    .obi_err_o    (obi_err_o),
    .mem_req_o    (mem_req_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_be_o     (mem_be_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // SRAM model: word 0 = 0x0BADF00D, words 1..3 = 0, word i>=4 = 0x1000_0000|i.
  always @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < 1024; i++) begin
        mem[i] <= (i == 0) ? 32'h0BAD_F00D : ((i < 4) ? 32'h0 : (32'h1000_0000 | 32'(i)));
      end
      mem_rdata_i <= 32'h0;
    end else if (mem_req_o && mem_gnt_i) begin
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_be_o[b]) mem[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
        end
      end else begin
        mem_rdata_i <= mem[mem_addr_o];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_ni = 1'b0; obi_req_i = 1'b0; obi_we_i = 1'b0; obi_addr_i = 32'h0;
    obi_be_i = 4'h0; obi_wdata_i = 32'h0; obi_aid_i = 1'b0;
    obi_rready_i = 1'b1; mem_gnt_i = 1'b1;

    // Reset held with a pending request
    repeat (2) @(negedge clk_i);
    obi_req_i = 1'b1; obi_addr_i = 32'h0001_0004;
    #1;
    chk("rst_gnt", obi_gnt_o, 0);
    chk("rst_rvalid", obi_rvalid_o, 0);
    chk("rst_mem_req", mem_req_o, 0);
    @(negedge clk_i); rst_ni = 1'b1;

    // SRAM busy blocks the grant, then first grant
    @(negedge clk_i); mem_gnt_i = 1'b0;
    #1;
    chk("busy_gnt", obi_gnt_o, 0);
    chk("busy_mem_req", mem_req_o, 1);
    @(negedge clk_i); mem_gnt_i = 1'b1;
    #1;
    chk("first_gnt", obi_gnt_o, 1);
    chk("first_mem_addr", mem_addr_o, 1);
    chk("first_mem_we", mem_we_o, 0);
    @(negedge clk_i); obi_req_i = 1'b0;
    #1;
    chk("first_rvalid", obi_rvalid_o, 1);
    chk("first_rdata", obi_rdata_o, 32'h0);
    chk("first_rid", obi_rid_o, 0);
    @(negedge clk_i); #1;
    chk("first_retired", obi_rvalid_o, 0);

    // Partial write
    @(negedge clk_i);
    obi_req_i = 1'b1; obi_we_i = 1'b1; obi_addr_i = 32'h0001_0008;
    obi_be_i = 4'b0011; obi_wdata_i = 32'hDEAD_BEEF; obi_aid_i = 1'b1;
    #1;
    chk("wr_gnt", obi_gnt_o, 1);
    chk("wr_mem_req", mem_req_o, 1);
    chk("wr_mem_we", mem_we_o, 1);
    chk("wr_mem_addr", mem_addr_o, 2);
    chk("wr_mem_be", mem_be_o, 4'h3);
    chk("wr_mem_wdata", mem_wdata_o, 32'hDEAD_BEEF);
    @(negedge clk_i); obi_req_i = 1'b0; obi_we_i = 1'b0;
    #1;
    chk("wr_rvalid", obi_rvalid_o, 1);
    chk("wr_rid", obi_rid_o, 1);
    chk("wr_rdata", obi_rdata_o, 32'h0);
    chk("wr_err", obi_err_o, 0);

    // Read back
    @(negedge clk_i);
    obi_req_i = 1'b1; obi_addr_i = 32'h0001_0008; obi_aid_i = 1'b0;
    #1;
    chk("rb_gnt", obi_gnt_o, 1);
    chk("rb_mem_addr", mem_addr_o, 2);
    @(negedge clk_i); obi_req_i = 1'b0;
    #1;
    chk("rb_rvalid", obi_rvalid_o, 1);
    chk("rb_rdata", obi_rdata_o, 32'h0000_BEEF);
    chk("rb_rid", obi_rid_o, 0);

    // Credit exhaustion with rready low, then same-cycle retire and re-grant
    @(negedge clk_i);
    obi_rready_i = 1'b0; obi_req_i = 1'b1; obi_addr_i = 32'h0001_0010; obi_aid_i = 1'b0;
    #1;
    chk("cr_gnt0", obi_gnt_o, 1);
    @(negedge clk_i); obi_addr_i = 32'h0001_0014; obi_aid_i = 1'b1;
    #1;
    chk("cr_gnt1", obi_gnt_o, 1);
    chk("cr_rdata0_early", obi_rdata_o, 32'h1000_0004);
    @(negedge clk_i); obi_addr_i = 32'h0001_0018; obi_aid_i = 1'b0;
    #1;
    chk("cr_full_gnt", obi_gnt_o, 0);
    chk("cr_full_mem_req", mem_req_o, 0);
    chk("cr_hold_rvalid", obi_rvalid_o, 1);
    chk("cr_hold_rdata", obi_rdata_o, 32'h1000_0004);
    chk("cr_hold_rid", obi_rid_o, 0);
    @(negedge clk_i); obi_rready_i = 1'b1;
    #1;
    chk("cr_regrant", obi_gnt_o, 1);
    chk("cr_pop_rdata", obi_rdata_o, 32'h1000_0004);
    @(negedge clk_i); obi_req_i = 1'b0; obi_rready_i = 1'b0;
    #1;
    chk("cr_rsp1_rdata", obi_rdata_o, 32'h1000_0005);
    chk("cr_rsp1_rid", obi_rid_o, 1);
    @(negedge clk_i); obi_rready_i = 1'b1;
    #1;
    chk("cr_rsp1_stable", obi_rdata_o, 32'h1000_0005);
    @(negedge clk_i); #1;
    chk("cr_rsp2_rvalid", obi_rvalid_o, 1);
    chk("cr_rsp2_rdata", obi_rdata_o, 32'h1000_0006);
    chk("cr_rsp2_rid", obi_rid_o, 0);
    @(negedge clk_i); #1;
    chk("cr_drained", obi_rvalid_o, 0);

    // Eight back-to-back reads, words 8..15
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      obi_req_i = 1'b1; obi_addr_i = 32'h0001_0000 + 32'(4 * (8 + i)); obi_aid_i = 1'(i);
      #1;
      chk($sformatf("b2b_gnt%0d", i), obi_gnt_o, 1);
      if (i > 0) begin
        chk($sformatf("b2b_rvalid%0d", i - 1), obi_rvalid_o, 1);
        chk($sformatf("b2b_rdata%0d", i - 1), obi_rdata_o, 32'h1000_0000 | 32'(8 + i - 1));
        chk($sformatf("b2b_rid%0d", i - 1), obi_rid_o, 64'((i - 1) % 2));
      end
    end
    @(negedge clk_i); obi_req_i = 1'b0;
    #1;
    chk("b2b_rvalid7", obi_rvalid_o, 1);
    chk("b2b_rdata7", obi_rdata_o, 32'h1000_000F);
    chk("b2b_rid7", obi_rid_o, 1);
    @(negedge clk_i); #1;
    chk("b2b_drained", obi_rvalid_o, 0);

    // Address beyond the bank
    @(negedge clk_i);
    obi_req_i = 1'b1; obi_addr_i = 32'h0002_0000; obi_aid_i = 1'b1;
`ifdef IDMA_OBI_RESP_ADDR_CHECK_EN
    mem_gnt_i = 1'b0;
    #1;
    chk("oor_gnt", obi_gnt_o, 1);
    chk("oor_mem_req", mem_req_o, 0);
    @(negedge clk_i); obi_req_i = 1'b0; mem_gnt_i = 1'b1;
    #1;
    chk("oor_rvalid", obi_rvalid_o, 1);
    chk("oor_err", obi_err_o, 1);
    chk("oor_rdata", obi_rdata_o, 32'h0);
    chk("oor_rid", obi_rid_o, 1);
`else
    #1;
    chk("wrap_gnt", obi_gnt_o, 1);
    chk("wrap_mem_req", mem_req_o, 1);
    chk("wrap_mem_addr", mem_addr_o, 0);
    @(negedge clk_i); obi_req_i = 1'b0;
    #1;
    chk("wrap_rvalid", obi_rvalid_o, 1);
    chk("wrap_err", obi_err_o, 0);
    chk("wrap_rdata", obi_rdata_o, 32'h0BAD_F00D);
    chk("wrap_rid", obi_rid_o, 1);
`endif

    // Reset with a response pending discards it
    @(negedge clk_i);
    obi_rready_i = 1'b0; obi_req_i = 1'b1; obi_addr_i = 32'h0001_0010; obi_aid_i = 1'b1;
    @(negedge clk_i); obi_req_i = 1'b0;
    #1;
    chk("mrst_pending", obi_rvalid_o, 1);
    rst_ni = 1'b0;
    #1;
    chk("mrst_cleared", obi_rvalid_o, 0);
    @(negedge clk_i); rst_ni = 1'b1; obi_rready_i = 1'b1;
    @(negedge clk_i); #1;
    chk("mrst_no_rsp0", obi_rvalid_o, 0);
    @(negedge clk_i); #1;
    chk("mrst_no_rsp1", obi_rvalid_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
